// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO pointer/status controller.
//   DEF_ADDR_WIDTH / DEPTH : default geometry of the register file
//   op_e                   : operation code formed from {do_rd, do_wr}
//   fifo_depth()           : entries for a given address width
package fifo_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 2;
  localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } op_e;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_flag_gen.sv
// Registered status flags for the FIFO controller, derived from the
// occupancy the controller will hold after the current edge.
//   clk, reset        : clock, asynchronous active-high reset
//   count_next        : occupancy after this edge (0..2**ADDR_WIDTH)
//   full, empty       : occupancy at capacity / zero
//   almost_full       : occupancy >= AF_LEVEL
//   almost_empty      : occupancy <= AE_LEVEL
module fifo_flag_gen
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_LEVEL   = 3,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   count_next,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_LEVEL);
  localparam logic                AF_RST  = (AF_LEVEL == 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= AF_RST;
      almost_empty <= 1'b1;
    end else begin
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and status controller for a FIFO built on a 2**ADDR_WIDTH-entry
// register file with an asynchronous read port.
//   clk, reset   : clock, asynchronous active-high reset
//   wr, rd       : push / pop requests
//   clr_err      : clears sticky overflow / underflow
//   wr_en        : register-file write enable (wr & ~full)
//   w_addr       : write pointer
//   r_addr       : read pointer
//   full, empty, almost_full, almost_empty : registered status flags
//   count        : occupancy 0..2**ADDR_WIDTH
//   overflow     : sticky, push requested while full
//   underflow    : sticky, pop requested while empty
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned AF_LEVEL   = 3,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned AW = ADDR_WIDTH;

  logic                do_wr;
  logic                do_rd;
  op_e                 op;
  logic [ADDR_WIDTH:0] count_next;

  // Requests are qualified by the registered flags, so count can never
  // step past DEPTH or below zero.
  assign do_wr = wr & ~full;
  assign do_rd = rd & ~empty;
  assign wr_en = do_wr;

  always_comb begin
    op         = op_e'({do_rd, do_wr});
    count_next = count;
    case (op)
      OP_WR:   count_next = count + CW'(1);
      OP_RD:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_addr <= '0;
      r_addr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) w_addr <= w_addr + AW'(1);
      if (do_rd) r_addr <= r_addr + AW'(1);
      count <= count_next;
    end
  end

  // Set has priority over clear when both land on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full)       overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (rd & empty)      underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  fifo_flag_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) u_flags (
    .clk          (clk),
    .reset        (reset),
    .count_next   (count_next),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl (ADDR_WIDTH=2, AF_LEVEL=3, AE_LEVEL=1).
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset, wr, rd, clr_err;
  logic       wr_en, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [1:0] w_addr, r_addr;
  logic [2:0] count;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic       wen;
    logic [1:0] wa;
    logic [1:0] ra;
    logic [2:0] cnt;
    logic [5:0] fl;   // {full, empty, almost_full, almost_empty, overflow, underflow}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fifo_ctrl #(
    .ADDR_WIDTH (2),
    .AF_LEVEL   (3),
    .AE_LEVEL   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .rd           (rd),
    .clr_err      (clr_err),
    .wr_en        (wr_en),
    .w_addr       (w_addr),
    .r_addr       (r_addr),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input exp_t e);
    chk("w_addr",       32'(w_addr),       32'(e.wa));
    chk("r_addr",       32'(r_addr),       32'(e.ra));
    chk("count",        32'(count),        32'(e.cnt));
    chk("full",         32'(full),         32'(e.fl[5]));
    chk("empty",        32'(empty),        32'(e.fl[4]));
    chk("almost_full",  32'(almost_full),  32'(e.fl[3]));
    chk("almost_empty", 32'(almost_empty), 32'(e.fl[2]));
    chk("overflow",     32'(overflow),     32'(e.fl[1]));
    chk("underflow",    32'(underflow),    32'(e.fl[0]));
  endtask

  // One clock of stimulus; the expected wr_en applies before the edge,
  // everything else to the state after the edge.
  task automatic step(input logic w, input logic r, input logic c, input logic wen,
                      input logic [1:0] wa, input logic [1:0] ra,
                      input logic [2:0] cnt, input logic [5:0] fl);
    exp_t e;
    @(negedge clk);
    wr = w; rd = r; clr_err = c;
    e.wen = wen; e.wa = wa; e.ra = ra; e.cnt = cnt; e.fl = fl;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle the stimulus issued one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_en", 32'(wr_en), 32'(e.wen));
        @(posedge clk);
        #1;
        chk_state(e);
      end
    end
  end

  initial begin
    exp_t rst_e;
    rst_e.wen = 1'b0; rst_e.wa = 2'd0; rst_e.ra = 2'd0; rst_e.cnt = 3'd0;
    rst_e.fl = 6'b010100;

    reset = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    #3;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk_state(rst_e);
    @(negedge clk);
    reset = 1'b0;

    // three pushes, then asynchronous reset mid-stream
    step(1,0,0, 1, 2'd1,2'd0,3'd1, 6'b000100);
    step(1,0,0, 1, 2'd2,2'd0,3'd2, 6'b000000);
    step(1,0,0, 1, 2'd3,2'd0,3'd3, 6'b001000);
    @(negedge clk);
    wr = 1'b0;
    reset = 1'b1;
    #1;
    chk_state(rst_e);
    @(negedge clk);
    reset = 1'b0;

    // fill, drain, refill across the wrap point
    step(1,0,0, 1, 2'd1,2'd0,3'd1, 6'b000100);
    step(1,0,0, 1, 2'd2,2'd0,3'd2, 6'b000000);
    step(1,0,0, 1, 2'd3,2'd0,3'd3, 6'b001000);
    step(1,0,0, 1, 2'd0,2'd0,3'd4, 6'b101000);
    step(0,1,0, 0, 2'd0,2'd1,3'd3, 6'b001000);
    step(0,1,0, 0, 2'd0,2'd2,3'd2, 6'b000000);
    step(0,1,0, 0, 2'd0,2'd3,3'd1, 6'b000100);
    step(0,1,0, 0, 2'd0,2'd0,3'd0, 6'b010100);
    step(1,0,0, 1, 2'd1,2'd0,3'd1, 6'b000100);
    step(1,0,0, 1, 2'd2,2'd0,3'd2, 6'b000000);
    step(1,0,0, 1, 2'd3,2'd0,3'd3, 6'b001000);
    step(1,0,0, 1, 2'd0,2'd0,3'd4, 6'b101000);

    // overflow: rejected write, sticky hold, clear, set-beats-clear
    step(1,0,0, 0, 2'd0,2'd0,3'd4, 6'b101010);
    step(0,0,0, 0, 2'd0,2'd0,3'd4, 6'b101010);
    step(0,0,1, 0, 2'd0,2'd0,3'd4, 6'b101000);
    step(1,0,1, 0, 2'd0,2'd0,3'd4, 6'b101010);
    step(0,0,1, 0, 2'd0,2'd0,3'd4, 6'b101000);

    // wr & rd while full: read proceeds, write rejected
    step(1,1,0, 0, 2'd0,2'd1,3'd3, 6'b001010);
    step(0,0,1, 0, 2'd0,2'd1,3'd3, 6'b001000);

    // drain to empty
    step(0,1,0, 0, 2'd0,2'd2,3'd2, 6'b000000);
    step(0,1,0, 0, 2'd0,2'd3,3'd1, 6'b000100);
    step(0,1,0, 0, 2'd0,2'd0,3'd0, 6'b010100);

    // wr & rd while empty: write proceeds, read ignored
    step(1,1,0, 1, 2'd1,2'd0,3'd1, 6'b000101);
    step(0,0,1, 0, 2'd1,2'd0,3'd1, 6'b000100);

    // reach count=2, then stream for 6 cycles
    step(1,0,0, 1, 2'd2,2'd0,3'd2, 6'b000000);
    step(1,1,0, 1, 2'd3,2'd1,3'd2, 6'b000000);
    step(1,1,0, 1, 2'd0,2'd2,3'd2, 6'b000000);
    step(1,1,0, 1, 2'd1,2'd3,3'd2, 6'b000000);
    step(1,1,0, 1, 2'd2,2'd0,3'd2, 6'b000000);
    step(1,1,0, 1, 2'd3,2'd1,3'd2, 6'b000000);
    step(1,1,0, 1, 2'd0,2'd2,3'd2, 6'b000000);

    @(negedge clk);
    wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
